// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable width, parity and stop bits.
// Majority-vote sampling, runtime divisor, valid/ready holding register.
module uart_rx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk100,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_m_q, rx_s_q;
  logic [2:0]           sh_q;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] tmr_q, tmr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] dsh_q, dsh_d;
  logic                 par_q, par_d;
  logic                 zero_q, zero_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 bk_q, bk_d;
  logic                 ov_q, ov_d;

  logic                 maj;
  logic                 tick;
  logic                 perr_w;
  logic [DIV_WIDTH-1:0] div_in;

  assign maj = (sh_q[0] & sh_q[1]) |
               (sh_q[0] & sh_q[2]) |
               (sh_q[1] & sh_q[2]);

  assign div_in = (baud_div < DIV_WIDTH'(4)) ?
                  DIV_WIDTH'(4) : baud_div;

  assign tick = (tmr_q == '0);

  assign perr_w = (PARITY == 1) ? ~par_q :
                  (PARITY == 2) ? par_q : 1'b0;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    dsh_d   = dsh_q;
    par_d   = par_q;
    zero_d  = zero_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    bk_d    = bk_q;
    ov_d    = ov_q;

    if (state_q != IDLE && state_q != WAIT_IDLE) begin
      tmr_d = tick ? div_q - DIV_WIDTH'(1)
                   : tmr_q - DIV_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        // previous rx_s high, current low
        if (sh_q[0] && !rx_s_q) begin
          state_d = START;
          div_d   = div_in;
          tmr_d   = (div_in >> 1) - DIV_WIDTH'(1);
          cnt_d   = '0;
          par_d   = 1'b0;
          zero_d  = 1'b1;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (tick) state_d = maj ? IDLE : DATA;
      end
      DATA: begin
        if (tick) begin
          dsh_d  = {maj, dsh_q[DATA_BITS-1:1]};
          par_d  = par_q ^ maj;
          zero_d = zero_q & ~maj;
          if (cnt_q == 4'(DATA_BITS - 1)) begin
            cnt_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          par_d   = par_q ^ maj;
          zero_d  = zero_q & ~maj;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          zero_d = zero_q & ~maj;
          ferr_d = ferr_q | ~maj;
          if (cnt_q == 4'(STOP_BITS - 1)) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = maj ? IDLE : WAIT_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      WAIT_IDLE: begin
        if (maj) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done_q) begin
      data_d  = dsh_q;
      fe_d    = ferr_q;
      pe_d    = perr_w;
      bk_d    = zero_q;
      valid_d = 1'b1;
      ov_d    = valid_q & ~ready;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
      ov_d    = 1'b0;
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      sh_q    <= 3'b111;
      div_q   <= DIV_WIDTH'(4);
      tmr_q   <= '0;
      cnt_q   <= '0;
      dsh_q   <= '0;
      par_q   <= 1'b0;
      zero_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      bk_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      sh_q    <= {sh_q[1:0], rx_s_q};
      div_q   <= div_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      dsh_q   <= dsh_d;
      par_q   <= par_d;
      zero_q  <= zero_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      bk_q    <= bk_d;
      ov_q    <= ov_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign break_det  = bk_q;
  assign overrun    = ov_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E1 instance.
// Frames are built from bit lists; expectations come from the frame contents.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rx1, rx2, rdy1, rdy2;
  logic [15:0] bd1, bd2;
  logic [7:0]  d1;
  logic [6:0]  d2;
  logic        v1, v2, fe1, fe2, pe1, pe2;
  logic        bk1, bk2, ov1, ov2;

  int  checks = 0;
  int  errors = 0;
  int  vcnt = 0;
  int  v0, raw, eff, b, sb, pb, lat;
  logic v1_prev = 1'b0;
  time t_rise = 0;
  time stop_mid = 0;

  uart_rx_cfg #(
    .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .DIV_WIDTH(16)
  ) dut1 (
    .clk100(clk), .rst(rst), .rx(rx1),
    .baud_div(bd1), .data(d1), .valid(v1),
    .ready(rdy1), .frame_err(fe1),
    .parity_err(pe1), .break_det(bk1),
    .overrun(ov1)
  );

  uart_rx_cfg #(
    .DATA_BITS(7), .PARITY(2),
    .STOP_BITS(1), .DIV_WIDTH(16)
  ) dut2 (
    .clk100(clk), .rst(rst), .rx(rx2),
    .baud_div(bd2), .data(d2), .valid(v2),
    .ready(rdy2), .frame_err(fe2),
    .parity_err(pe2), .break_det(bk2),
    .overrun(ov2)
  );

  always @(negedge clk) begin
    if (v1) vcnt++;
    if (v1 && !v1_prev) t_rise = $time;
    v1_prev = v1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic bv);
    if (sel == 0) rx1 = bv;
    else rx2 = bv;
  endtask

  // start bit, data LSB first, optional parity, one stop bit
  task automatic send(input int sel, input int div,
                      input int nb, input logic [8:0] d,
                      input int pbit, input logic sbit,
                      input int g);
    drive(sel, 1'b0);
    repeat (div) @(posedge clk);
    for (int i = 0; i < nb; i++) begin
      drive(sel, d[i]);
      if (i == g) begin
        repeat (6) @(posedge clk);
        drive(sel, ~d[i]);
        @(posedge clk);
        drive(sel, d[i]);
        repeat (div - 7) @(posedge clk);
      end else begin
        repeat (div) @(posedge clk);
      end
    end
    if (pbit >= 0) begin
      drive(sel, pbit[0]);
      repeat (div) @(posedge clk);
    end
    stop_mid = $time + (div / 2) * 10;
    drive(sel, sbit);
    repeat (div) @(posedge clk);
    drive(sel, 1'b1);
  endtask

  task automatic wait_valid(input string tag,
                            input int sel,
                            input int maxc);
    int n;
    logic vv;
    n = 0;
    @(negedge clk);
    vv = (sel == 0) ? v1 : v2;
    while (!vv && n < maxc) begin
      @(negedge clk);
      n++;
      vv = (sel == 0) ? v1 : v2;
    end
    check(tag, vv, 1);
  endtask

  task automatic consume(input int sel);
    @(negedge clk);
    if (sel == 0) rdy1 = 1'b1;
    else rdy2 = 1'b1;
    @(posedge clk);
    #1;
    rdy1 = 1'b0;
    rdy2 = 1'b0;
    @(negedge clk);
    if (sel == 0) begin
      check("cons_v1", v1, 0);
      check("cons_ov1", ov1, 0);
    end else begin
      check("cons_v2", v2, 0);
    end
  endtask

  initial begin
    rst  = 1'b1;
    rx1  = 1'b1;
    rx2  = 1'b1;
    rdy1 = 1'b0;
    rdy2 = 1'b0;
    bd1  = 16'd16;
    bd2  = 16'd10;
    repeat (3) @(negedge clk);
    check("rst_valid", v1, 0);
    check("rst_data", d1, 0);
    check("rst_flags", {fe1, pe1, bk1, ov1}, 0);
    check("rst_valid2", v2, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // 8N1 0xA5 with ready held high
    rdy1 = 1'b1;
    v0 = vcnt;
    send(0, 16, 8, 9'h0A5, -1, 1'b1, -1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("a5_pulses", vcnt - v0, 1);
    check("a5_data", d1, 8'hA5);
    check("a5_flags", {fe1, pe1, bk1, ov1}, 0);
    lat = int'((t_rise - stop_mid) / 10);
    check("a5_latency", (lat >= 0 && lat <= 16), 1);
    rdy1 = 1'b0;

    // glitch at a data-bit midpoint
    send(0, 16, 8, 9'h0B3, -1, 1'b1, 2);
    wait_valid("gl_valid", 0, 200);
    check("gl_data", d1, 8'hB3);
    consume(0);

    // false start
    drive(0, 1'b0);
    repeat (3) @(posedge clk);
    drive(0, 1'b1);
    repeat (16 * 12) @(posedge clk);
    @(negedge clk);
    check("fs_valid", v1, 0);

    // randomized 8N1 frames, including clamped divisors
    for (int i = 0; i < 16; i++) begin
      raw = $urandom_range(0, 20);
      eff = (raw < 4) ? 4 : raw;
      bd1 = 16'(raw);
      b   = $urandom_range(0, 255);
      sb  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      send(0, eff, 8, 9'(b), -1, sb[0], -1);
      wait_valid("r1_valid", 0, 300);
      check("r1_data", d1, b);
      check("r1_ferr", fe1, (sb == 0));
      check("r1_perr", pe1, 0);
      check("r1_brk", bk1, (b == 0 && sb == 0));
      check("r1_ovr", ov1, 0);
      consume(0);
      repeat ($urandom_range(4, 20)) @(posedge clk);
    end

    // overrun
    bd1 = 16'd16;
    send(0, 16, 8, 9'h011, -1, 1'b1, -1);
    wait_valid("ov_v1", 0, 200);
    check("ov_first", ov1, 0);
    send(0, 16, 8, 9'h022, -1, 1'b1, -1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("ov_data", d1, 8'h22);
    check("ov_valid", v1, 1);
    check("ov_flag", ov1, 1);
    consume(0);

    // divisor change mid-frame
    fork
      send(0, 16, 8, 9'h096, -1, 1'b1, -1);
      begin
        repeat (64) @(posedge clk);
        bd1 = 16'd8;
      end
    join
    wait_valid("dv_v1", 0, 200);
    check("dv_data16", d1, 8'h96);
    consume(0);
    repeat (10) @(posedge clk);
    send(0, 8, 8, 9'h069, -1, 1'b1, -1);
    wait_valid("dv_v2", 0, 200);
    check("dv_data8", d1, 8'h69);
    check("dv_flags", {fe1, pe1, bk1}, 0);
    consume(0);

    // break
    bd1 = 16'd16;
    drive(0, 1'b0);
    repeat (16 * 12) @(posedge clk);
    @(negedge clk);
    check("bk_valid", v1, 1);
    check("bk_data", d1, 0);
    check("bk_ferr", fe1, 1);
    check("bk_brk", bk1, 1);
    consume(0);
    repeat (16 * 4) @(posedge clk);
    @(negedge clk);
    check("bk_nomore", v1, 0);
    drive(0, 1'b1);
    repeat (32) @(posedge clk);
    send(0, 16, 8, 9'h055, -1, 1'b1, -1);
    wait_valid("bk55_v", 0, 200);
    check("bk55_data", d1, 8'h55);
    check("bk55_flags", {fe1, pe1, bk1, ov1}, 0);

    // reset mid-frame, with 0x55 still held
    drive(0, 1'b0);
    repeat (16) @(posedge clk);
    drive(0, 1'b0);
    repeat (32) @(posedge clk);
    drive(0, 1'b1);
    repeat (8) @(posedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_valid", v1, 0);
    check("mr_data", d1, 0);
    check("mr_flags", {fe1, pe1, bk1, ov1}, 0);
    repeat (4) @(posedge clk);
    rst = 1'b0;
    repeat (16 * 12) @(posedge clk);
    @(negedge clk);
    check("mr_after", v1, 0);
    send(0, 16, 8, 9'h03C, -1, 1'b1, -1);
    wait_valid("mr3c_v", 0, 200);
    check("mr3c_data", d1, 8'h3C);
    consume(0);

    // 7E1: wrong then correct parity for 0x03
    send(1, 10, 7, 9'h003, 1, 1'b1, -1);
    wait_valid("p_bad_v", 1, 200);
    check("p_bad_data", d2, 7'h03);
    check("p_bad_perr", pe2, 1);
    check("p_bad_ferr", fe2, 0);
    consume(1);
    repeat (10) @(posedge clk);
    send(1, 10, 7, 9'h003, 0, 1'b1, -1);
    wait_valid("p_ok_v", 1, 200);
    check("p_ok_data", d2, 7'h03);
    check("p_ok_perr", pe2, 0);
    consume(1);

    // randomized 7E1 frames
    for (int i = 0; i < 10; i++) begin
      raw = $urandom_range(0, 20);
      eff = (raw < 4) ? 4 : raw;
      bd2 = 16'(raw);
      b   = $urandom_range(0, 127);
      pb  = $urandom_range(0, 1);
      repeat ($urandom_range(4, 20)) @(posedge clk);
      send(1, eff, 7, 9'(b), pb, 1'b1, -1);
      wait_valid("r2_valid", 1, 300);
      check("r2_data", d2, b);
      check("r2_perr", pe2,
            (($countones(b) + pb) % 2) != 0);
      check("r2_ferr", fe2, 0);
      check("r2_brk", bk2, 0);
      consume(1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. It adds configurable data width, parity and stop bits, and a runtime baud divisor. It synchronises rx, uses majority-vote sampling, and reports framing, parity, break and overrun status. Output is a valid/ready holding register that feeds the terminal input path.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits checked, 1 or 2
DIV_WIDTH, 16, width of baud_div

Ports:
clk100  in  1  system clock
rst  in  1  asynchronous active-high reset
rx  in  1  serial line, asynchronous, idle high
baud_div  in  DIV_WIDTH  clocks per bit; values below 4 are treated as 4
data  out  DATA_BITS  received word, LSB is first bit on wire
valid  out  1  data/flags hold an unconsumed frame
ready  in  1  consumer accepts frame when valid & ready
frame_err  out  1  a checked stop bit was sampled low
parity_err  out  1  parity mismatch (always 0 when PARITY=0)
break_det  out  1  all data, parity and stop bits sampled low
overrun  out  1  a frame overwrote an unconsumed frame

Behaviour:
- Clock and reset: single clock clk100. rst is asynchronous, active-high. During reset every output is 0, state is IDLE, and the synchroniser and sample registers are 1.
- Input sampling: rx passes through a 2-FF synchroniser (rx_s), then a 3-bit shift register. maj is the majority of the last 3 rx_s samples.
- Bit timing:
  - div is latched from baud_div (clamped to >= 4) on start detection. Changes to baud_div mid-frame have no effect.
  - The bit timer reloads with div-1 and samples maj when it reaches 0.
- State machine: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - A falling edge on rx_s (previous 1, now 0) moves to START with timer = (div>>1)-1.
  - A line that is already low (e.g. after reset) does not trigger.
- START: at timer 0, maj=0 moves to DATA. maj=1 is a false start: return to IDLE, no output, no flags.
- DATA:
  - DATA_BITS samples, LSB first, shifted into a DATA_BITS-wide register.
  - Then go to PARITY if PARITY != 0, else to STOP.
- PARITY: one sample.
  - Odd: XOR of data bits and parity bit must be 1.
  - Even: that XOR must be 0.
- STOP:
  - STOP_BITS samples. Any low sample sets the pending frame_err.
  - After the last stop sample the frame completes. Go to IDLE if the last sample was high, else to WAIT_IDLE.
- WAIT_IDLE: stay until maj=1, then IDLE. A held-low line produces exactly one frame.
- Break: break_det=1 when all data, parity (if any) and stop samples are 0. frame_err is also 1 in that case.
- Frame completion, registered on the next clock edge after the final stop sample:
  - data and all three error flags load.
  - valid goes to 1.
  - Frames with errors are still delivered with their flags.
- Handshake:
  - valid & ready on a clock edge clears valid and overrun. data and flags hold their values.
  - Completion while valid=1 and not consumed that cycle: data and flags overwrite, valid stays 1, overrun is set and held until consumed.
  - Completion on the same edge as a consume: new frame loads, valid stays 1, overrun=0.
- Reset mid-frame: the frame is discarded. After release, the next falling edge starts a new frame.
- Back-to-back frames: a start bit immediately following the stop bit is detected, because IDLE is entered at the stop sample point.

Test Plan:
- 8N1, div=16, send 0xA5 (ready held 1) -> exactly one valid pulse with data=0xA5, all flags 0. valid rises within 16 clocks after the stop-bit midpoint.
- DATA_BITS=7, PARITY=2, div=10, send 0x03 with parity bit 1 (wrong) -> data=0x03, parity_err=1. Same frame with parity 0 -> parity_err=0.
- False start: rx low for 3 clocks at div=16 -> no valid. A 1-clock high glitch at a data-bit midpoint -> bit still read correctly via the majority vote.
- Break: rx low for 12 bit times at div=16, then high -> one frame with data=0, frame_err=1, break_det=1. No further frame until the line returns high, then a following 0x55 is received cleanly.
- Overrun: send 0x11 then 0x22 with ready=0 -> data=0x22, valid=1, overrun=1. One ready cycle -> valid=0, overrun=0.
- Reset and divisor: assert rst mid-way through 0x3C -> outputs 0 and no valid after release. Change baud_div mid-frame from 16 to 8 -> current frame decodes at 16; next frame decodes at 8.
